// File: rtl/counter_run_ctrl_if.sv
// Register bus between the run sequencer (master) and counter_top (slave).
// Plain strobe bus: no handshake, the slave answers reads combinationally.
interface counter_run_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        overflow;

  modport master (
    output wr_en, rd_en, addr, wdata,
    input  rdata, overflow
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata,
    output rdata, overflow
  );
endinterface

// File: rtl/counter_run_ctrl.sv
// Timed count sequencer: clear, enable for run_len edges, stop, read STATUS; done at cycle N+4 after go.
// No backpressure: go is ignored while busy, abort is honoured only while counting.
module counter_run_ctrl #(
  parameter int         LEN_W     = 16,
  parameter logic [9:0] CTRL_ADDR = 10'h000,
  parameter logic [9:0] STAT_ADDR = 10'h004
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [LEN_W-1:0] run_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result,
  output logic [7:0]       ovf_hits,
  output logic             aborted,
  counter_run_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_START,
    S_RUN,
    S_STOP,
    S_READ,
    S_DONE
  } state_t;

  localparam logic [31:0] CTRL_CLEAR = 32'h0000_0002;
  localparam logic [31:0] CTRL_EN    = 32'h0000_0001;
  localparam logic [31:0] CTRL_OFF   = 32'h0000_0000;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             ovf_prev;
  logic             ovf_rise;
  logic             ovf_track;
  logic             unused_rdata_hi;

  assign unused_rdata_hi = ^bus.rdata[31:8];

  // Overflow edges only count while the counter is enabled or just stopped.
  assign ovf_track = (state == S_RUN) || (state == S_STOP) || (state == S_READ);
  assign ovf_rise  = bus.overflow && !ovf_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      ovf_prev <= 1'b0;
      ovf_hits <= 8'd0;
      result   <= 8'd0;
      aborted  <= 1'b0;
    end else begin
      ovf_prev <= bus.overflow;
      if (ovf_track && ovf_rise && (ovf_hits != 8'hFF)) begin
        ovf_hits <= ovf_hits + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (go) begin
            state    <= S_CLR;
            len_q    <= (run_len == '0) ? LEN_W'(1) : run_len;
            aborted  <= 1'b0;
            ovf_hits <= 8'd0;
            ovf_prev <= 1'b0;
          end
        end
        S_CLR: begin
          state <= S_START;
        end
        S_START: begin
          cnt_q <= len_q - LEN_W'(1);
          state <= (len_q == LEN_W'(1)) ? S_STOP : S_RUN;
        end
        S_RUN: begin
          cnt_q <= cnt_q - LEN_W'(1);
          if (abort) begin
            state   <= S_STOP;
            aborted <= 1'b1;
          end else if (cnt_q == LEN_W'(1)) begin
            state <= S_STOP;
          end
        end
        S_STOP: begin
          state <= S_READ;
        end
        S_READ: begin
          result <= bus.rdata[7:0];
          state  <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus decoded straight from state so a reset idles it without waiting for an edge.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = 10'h000;
    bus.wdata = 32'h0;
    case (state)
      S_CLR: begin
        bus.wr_en = 1'b1;
        bus.addr  = CTRL_ADDR;
        bus.wdata = CTRL_CLEAR;
      end
      S_START: begin
        bus.wr_en = 1'b1;
        bus.addr  = CTRL_ADDR;
        bus.wdata = CTRL_EN;
      end
      S_STOP: begin
        bus.wr_en = 1'b1;
        bus.addr  = CTRL_ADDR;
        bus.wdata = CTRL_OFF;
      end
      S_READ: begin
        bus.rd_en = 1'b1;
        bus.addr  = STAT_ADDR;
      end
      default: begin
        bus.wr_en = 1'b0;
      end
    endcase
  end

endmodule
